// File: rtl/ft2232_fifo_device_if.sv
//------------------------------------------------------------------------------
// Module      : ft2232_fifo_device_if
// Description : FT2232H 245 synchronous FIFO handshake signals shared by the
//               FPGA-side master and the device-side responder. The 8-bit
//               data bus is a bidirectional net, so it stays a plain inout
//               port on the device rather than living in this interface.
//   fifo_rxf_n  device -> master  low = RX data available
//   fifo_txe_n  device -> master  low = TX space available
//   fifo_oe_n   master -> device  low = device drives the data bus
//   fifo_rd_n   master -> device  low = master consumes an RX byte
//   fifo_wr_n   master -> device  low = master writes a TX byte
//   fifo_siwu   master -> device  send-immediate, ignored by the device
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ft2232_fifo_device_if;
  logic fifo_rxf_n;
  logic fifo_txe_n;
  logic fifo_oe_n;
  logic fifo_rd_n;
  logic fifo_wr_n;
  logic fifo_siwu;

  modport master (
    input  fifo_rxf_n, fifo_txe_n,
    output fifo_oe_n, fifo_rd_n, fifo_wr_n, fifo_siwu
  );

  modport slave (
    output fifo_rxf_n, fifo_txe_n,
    input  fifo_oe_n, fifo_rd_n, fifo_wr_n, fifo_siwu
  );
endinterface

`default_nettype wire

// File: rtl/ft2232_fifo_device.sv
//------------------------------------------------------------------------------
// Module      : ft2232_fifo_device
// Description : Responder model of one FT2232HQ channel in 245 synchronous
//               FIFO mode. A host-side push port fills an RX buffer that the
//               FPGA master reads over the bus; bytes the master writes land
//               in a TX buffer that the host pops. TXE# is paced to mimic USB
//               packet boundaries so master throttling paths get exercised.
// Ports       :
//   fifo_clk_i        bus clock
//   reset_i           asynchronous active-high reset
//   ft2232_reset_n_i  synchronous clear from the master (active low)
//   bus               handshake signals (slave modport)
//   fifo_data_io      shared 8-bit data bus
//   host_wr_*         RX buffer push port (host side)
//   host_rd_*         TX buffer pop port, show-ahead (host side)
//   rx_count_o        RX occupancy, tx_count_o TX occupancy
//   err_o             sticky: [0] contention, [1] RX underrun, [2] TX overrun
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ft2232_fifo_device #(
  parameter int RX_ASIZE = 6,
  parameter int TX_ASIZE = 6,
  parameter int TX_PKT   = 16,
  parameter int TXE_HOLD = 4
) (
  input  logic                    fifo_clk_i,
  input  logic                    reset_i,
  input  logic                    ft2232_reset_n_i,
  ft2232_fifo_device_if.slave     bus,
  inout  wire  [7:0]              fifo_data_io,
  input  logic                    host_wr_en_i,
  input  logic [7:0]              host_wr_data_i,
  output logic                    host_wr_full_o,
  input  logic                    host_rd_en_i,
  output logic [7:0]              host_rd_data_o,
  output logic                    host_rd_empty_o,
  output logic [RX_ASIZE:0]       rx_count_o,
  output logic [TX_ASIZE:0]       tx_count_o,
  output logic [2:0]              err_o
);

  localparam int RX_DEPTH = 1 << RX_ASIZE;
  localparam int TX_DEPTH = 1 << TX_ASIZE;
  localparam logic [RX_ASIZE:0] C_RX_FULL = {1'b1, {RX_ASIZE{1'b0}}};
  localparam logic [TX_ASIZE:0] C_TX_FULL = {1'b1, {TX_ASIZE{1'b0}}};

  localparam int PKT_W  = (TX_PKT > 1) ? $clog2(TX_PKT) : 1;
  localparam int HOLD_W = (TXE_HOLD > 1) ? $clog2(TXE_HOLD) : 1;
  localparam logic [PKT_W-1:0]  C_PKT_LAST  = PKT_W'(TX_PKT - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(TXE_HOLD - 1);

  typedef enum logic [0:0] {
    TX_OPEN = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_e;

  // Storage
  logic [7:0]          rx_mem_q [RX_DEPTH];
  logic [7:0]          tx_mem_q [TX_DEPTH];

  // State
  logic [RX_ASIZE-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RX_ASIZE-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_ASIZE:0]   rx_count_q,  rx_count_d;
  logic [TX_ASIZE-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TX_ASIZE-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_ASIZE:0]   tx_count_q,  tx_count_d;
  logic                rxf_n_q,     rxf_n_d;
  logic                txe_n_q,     txe_n_d;
  logic [2:0]          err_q,       err_d;
  tx_state_e           state_q,     state_d;
  logic [PKT_W-1:0]    pkt_cnt_q,   pkt_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;

  // Events for the upcoming edge
  logic w_rx_push, w_rx_pop, w_tx_acc, w_tx_pop;
  logic w_cont, w_under, w_over;

  logic unused_siwu;
  assign unused_siwu = bus.fifo_siwu;

  // Device drives the bus purely from OE# so data is valid the cycle OE# falls
  assign fifo_data_io = bus.fifo_oe_n ? 8'hzz : rx_mem_q[rx_rd_ptr_q];

  assign bus.fifo_rxf_n  = rxf_n_q;
  assign bus.fifo_txe_n  = txe_n_q;
  assign host_wr_full_o  = (rx_count_q == C_RX_FULL);
  assign host_rd_empty_o = (tx_count_q == '0);
  assign host_rd_data_o  = tx_mem_q[tx_rd_ptr_q];
  assign rx_count_o      = rx_count_q;
  assign tx_count_o      = tx_count_q;
  assign err_o           = err_q;

  always_comb begin
    w_rx_push = host_wr_en_i && !host_wr_full_o;
    w_rx_pop  = !bus.fifo_rd_n && !bus.fifo_oe_n && !rxf_n_q;
    // A write is never taken while the device itself owns the bus
    w_tx_acc  = !bus.fifo_wr_n && bus.fifo_oe_n && !txe_n_q;
    w_tx_pop  = host_rd_en_i && !host_rd_empty_o;
    w_cont    = !bus.fifo_oe_n && !bus.fifo_wr_n;
    w_under   = !bus.fifo_rd_n && rxf_n_q;
    w_over    = !bus.fifo_wr_n && txe_n_q;
  end

  // Pointer / occupancy / flag next state
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q + RX_ASIZE'(w_rx_push);
    rx_rd_ptr_d = rx_rd_ptr_q + RX_ASIZE'(w_rx_pop);
    rx_count_d  = rx_count_q;
    if (w_rx_push && !w_rx_pop) begin
      rx_count_d = rx_count_q + 1'b1;
    end else if (!w_rx_push && w_rx_pop) begin
      rx_count_d = rx_count_q - 1'b1;
    end
    rxf_n_d = (rx_count_d == '0);

    tx_wr_ptr_d = tx_wr_ptr_q + TX_ASIZE'(w_tx_acc);
    tx_rd_ptr_d = tx_rd_ptr_q + TX_ASIZE'(w_tx_pop);
    tx_count_d  = tx_count_q;
    if (w_tx_acc && !w_tx_pop) begin
      tx_count_d = tx_count_q + 1'b1;
    end else if (!w_tx_acc && w_tx_pop) begin
      tx_count_d = tx_count_q - 1'b1;
    end

    err_d = err_q | {w_over, w_under, w_cont};
  end

  // TX pacing: TXE# follows buffer space, except for a forced-high hold
  // window after every TX_PKT accepted bytes.
  always_comb begin
    state_d    = state_q;
    pkt_cnt_d  = pkt_cnt_q;
    hold_cnt_d = hold_cnt_q;
    txe_n_d    = (tx_count_d == C_TX_FULL);
    case (state_q)
      TX_OPEN: begin
        if ((TX_PKT != 0) && w_tx_acc) begin
          if (pkt_cnt_q == C_PKT_LAST) begin
            pkt_cnt_d = '0;
            if (TXE_HOLD != 0) begin
              state_d    = TX_HOLD;
              hold_cnt_d = '0;
              txe_n_d    = 1'b1;
            end
          end else begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end
        end
      end
      TX_HOLD: begin
        txe_n_d = 1'b1;
        if (hold_cnt_q == C_HOLD_LAST) begin
          state_d = TX_OPEN;
          txe_n_d = (tx_count_d == C_TX_FULL);
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_OPEN;
      end
    endcase
  end

  always_ff @(posedge fifo_clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rxf_n_q     <= 1'b1;
      txe_n_q     <= 1'b1;
      err_q       <= '0;
      state_q     <= TX_OPEN;
      pkt_cnt_q   <= '0;
      hold_cnt_q  <= '0;
    end else if (!ft2232_reset_n_i) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rxf_n_q     <= 1'b1;
      txe_n_q     <= 1'b1;
      err_q       <= '0;
      state_q     <= TX_OPEN;
      pkt_cnt_q   <= '0;
      hold_cnt_q  <= '0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rxf_n_q     <= rxf_n_d;
      txe_n_q     <= txe_n_d;
      err_q       <= err_d;
      state_q     <= state_d;
      pkt_cnt_q   <= pkt_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Buffer contents need no reset; occupancy decides what is valid
  always_ff @(posedge fifo_clk_i) begin
    if (w_rx_push) begin
      rx_mem_q[rx_wr_ptr_q] <= host_wr_data_i;
    end
    if (w_tx_acc) begin
      tx_mem_q[tx_wr_ptr_q] <= fifo_data_io;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ft2232_fifo_device.sv
//------------------------------------------------------------------------------
// Module      : tb_ft2232_fifo_device
// Description : Self-checking bench for ft2232_fifo_device. A monitor keeps a
//               queue-based model of both buffers and of TXE# packet pacing
//               and compares every bus byte, host pop, flag and counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ft2232_fifo_device;

  localparam int RX_ASIZE = 6;
  localparam int TX_ASIZE = 6;
  localparam int TX_PKT   = 16;
  localparam int TXE_HOLD = 4;
  localparam int RX_DEPTH = 64;
  localparam int TX_DEPTH = 64;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       ft_rst_n;
  logic       host_wr_en;
  logic [7:0] host_wr_data;
  logic       host_wr_full;
  logic       host_rd_en;
  logic [7:0] host_rd_data;
  logic       host_rd_empty;
  logic [6:0] rx_count;
  logic [6:0] tx_count;
  logic [2:0] err;
  wire  [7:0] fifo_data;
  logic [7:0] m_data;
  logic       m_drive;

  assign fifo_data = m_drive ? m_data : 8'hzz;

  ft2232_fifo_device_if bus_if ();

  ft2232_fifo_device #(
    .RX_ASIZE (RX_ASIZE),
    .TX_ASIZE (TX_ASIZE),
    .TX_PKT   (TX_PKT),
    .TXE_HOLD (TXE_HOLD)
  ) dut (
    .fifo_clk_i       (clk),
    .reset_i          (reset_i),
    .ft2232_reset_n_i (ft_rst_n),
    .bus              (bus_if),
    .fifo_data_io     (fifo_data),
    .host_wr_en_i     (host_wr_en),
    .host_wr_data_i   (host_wr_data),
    .host_wr_full_o   (host_wr_full),
    .host_rd_en_i     (host_rd_en),
    .host_rd_data_o   (host_rd_data),
    .host_rd_empty_o  (host_rd_empty),
    .rx_count_o       (rx_count),
    .tx_count_o       (tx_count),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int         hold_left = 0;
  int         pkt_acc   = 0;
  bit         fresh     = 1'b1;   // TXE# held high until the first edge after a reset
  logic [2:0] err_m     = 3'b000;

  function automatic bit model_txe();
    return fresh || (hold_left > 0) || (tx_q.size() == TX_DEPTH);
  endfunction

  task automatic model_clear();
    rx_q.delete();
    tx_q.delete();
    hold_left = 0;
    pkt_acc   = 0;
    fresh     = 1'b1;
    err_m     = 3'b000;
  endtask

  // Monitor: samples after the inputs for the next edge have settled,
  // compares the state left by the previous edge, then predicts the next one.
  always @(negedge clk) begin
    bit rx_pop, rx_push, tx_acc, tx_pop, txe_m;
    #2;
    if (reset_i) model_clear();
    chk("rx_count", 32'(rx_count), 32'(rx_q.size()));
    chk("rxf_n", 32'(bus_if.fifo_rxf_n), 32'(rx_q.size() == 0));
    chk("wr_full", 32'(host_wr_full), 32'(rx_q.size() == RX_DEPTH));
    chk("tx_count", 32'(tx_count), 32'(tx_q.size()));
    chk("rd_empty", 32'(host_rd_empty), 32'(tx_q.size() == 0));
    chk("txe_n", 32'(bus_if.fifo_txe_n), 32'(model_txe()));
    chk("err", 32'(err), 32'(err_m));
    if (!reset_i) begin
      if (!ft_rst_n) begin
        model_clear();
      end else begin
        txe_m   = model_txe();
        rx_pop  = !bus_if.fifo_rd_n && !bus_if.fifo_oe_n && (rx_q.size() > 0);
        rx_push = host_wr_en && (rx_q.size() < RX_DEPTH);
        tx_acc  = !bus_if.fifo_wr_n && bus_if.fifo_oe_n && !txe_m;
        tx_pop  = host_rd_en && (tx_q.size() > 0);
        if (!bus_if.fifo_oe_n && !bus_if.fifo_wr_n) err_m[0] = 1'b1;
        if (!bus_if.fifo_rd_n && rx_q.size() == 0)  err_m[1] = 1'b1;
        if (!bus_if.fifo_wr_n && txe_m)             err_m[2] = 1'b1;
        if (!bus_if.fifo_oe_n && rx_q.size() > 0)
          chk("bus_drive", 32'(fifo_data), 32'(rx_q[0]));
        if (rx_pop) begin
          chk("rx_byte", 32'(fifo_data), 32'(rx_q[0]));
          void'(rx_q.pop_front());
        end
        if (rx_push) rx_q.push_back(host_wr_data);
        if (tx_pop) begin
          chk("tx_byte", 32'(host_rd_data), 32'(tx_q[0]));
          void'(tx_q.pop_front());
        end
        if (tx_acc) tx_q.push_back(m_data);
        if (hold_left > 0) begin
          hold_left--;
        end else if (tx_acc && TX_PKT != 0) begin
          pkt_acc++;
          if (pkt_acc == TX_PKT) begin
            pkt_acc   = 0;
            hold_left = TXE_HOLD;
          end
        end
        fresh = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus_if.fifo_oe_n = 1'b1;
    bus_if.fifo_rd_n = 1'b1;
    bus_if.fifo_wr_n = 1'b1;
    m_drive          = 1'b0;
    host_wr_en       = 1'b0;
    host_rd_en       = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_clear();
    @(negedge clk);
    idle();
    ft_rst_n = 1'b0;
    @(negedge clk);
    ft_rst_n = 1'b1;
    tick(2);
  endtask

  task automatic host_push(input logic [7:0] d);
    @(negedge clk);
    host_wr_en   = 1'b1;
    host_wr_data = d;
  endtask

  // Well-behaved master: writes only while TXE# is low
  task automatic master_write(input int n, input logic [7:0] base, output int cyc);
    int sent;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (bus_if.fifo_txe_n === 1'b0) begin
        bus_if.fifo_wr_n = 1'b0;
        m_drive          = 1'b1;
        m_data           = base + 8'(sent);
        sent++;
      end else begin
        bus_if.fifo_wr_n = 1'b1;
        m_drive          = 1'b0;
      end
    end
    chk("write_budget", 32'(sent), 32'(n));
    @(negedge clk);
    bus_if.fifo_wr_n = 1'b1;
    m_drive          = 1'b0;
  endtask

  task automatic consume(input int n);
    @(negedge clk);
    idle();
    bus_if.fifo_oe_n = 1'b0;
    repeat (n) begin
      @(negedge clk);
      bus_if.fifo_rd_n = 1'b0;
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    reset_i          = 1'b1;
    ft_rst_n         = 1'b1;
    bus_if.fifo_siwu = 1'b1;
    host_wr_data     = 8'h00;
    m_data           = 8'h00;
    idle();
    tick(3);
    chk("rst_rxf_n", 32'(bus_if.fifo_rxf_n), 32'd1);
    chk("rst_txe_n", 32'(bus_if.fifo_txe_n), 32'd1);
    chk("rst_full", 32'(host_wr_full), 32'd0);
    chk("rst_empty", 32'(host_rd_empty), 32'd1);
    chk("rst_counts", 32'({rx_count, tx_count}), 32'd0);
    reset_i = 1'b0;
    tick(2);

    // 1: push 0x10..0x17 then back-to-back reads
    for (int i = 0; i < 8; i++) host_push(8'h10 + 8'(i));
    @(negedge clk);
    idle();
    consume(8);
    tick(1);
    chk("t1_rx_count", 32'(rx_count), 32'd0);
    chk("t1_rxf_n", 32'(bus_if.fifo_rxf_n), 32'd1);
    chk("t1_err", 32'(err), 32'd0);

    // 2: 40 paced writes, then host drains in order
    sync_clear();
    master_write(40, 8'h00, cyc);
    chk("t2_cycles", 32'(cyc), 32'(40 + ((40 - 1) / TX_PKT) * TXE_HOLD));
    tick(1);
    chk("t2_tx_count", 32'(tx_count), 32'd40);
    chk("t2_head", 32'(host_rd_data), 32'h00);
    host_rd_en = 1'b1;
    tick(40);
    host_rd_en = 1'b0;
    tick(1);
    chk("t2_empty", 32'(host_rd_empty), 32'd1);

    // 3: fill RX, overflow push dropped, drain; second fill exercises wrap
    sync_clear();
    for (int i = 0; i < RX_DEPTH; i++) host_push(8'($urandom));
    host_push(8'hAA);
    @(negedge clk);
    idle();
    chk("t3_full", 32'(host_wr_full), 32'd1);
    chk("t3_count", 32'(rx_count), 32'(RX_DEPTH));
    consume(RX_DEPTH);
    for (int i = 0; i < RX_DEPTH; i++) host_push(8'($urandom));
    @(negedge clk);
    idle();
    bus_if.fifo_oe_n = 1'b0;
    for (int i = 0; i < 400 && rx_count != 0; i++) begin
      @(negedge clk);
      bus_if.fifo_rd_n = (bus_if.fifo_rxf_n === 1'b0 && $urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    idle();
    tick(1);
    chk("t3_drained", 32'(rx_count), 32'd0);

    // 4: underrun then overrun during the hold window
    @(negedge clk);
    bus_if.fifo_oe_n = 1'b0;
    bus_if.fifo_rd_n = 1'b0;
    @(negedge clk);
    idle();
    tick(1);
    chk("t4_err_under", 32'(err), 32'b010);
    chk("t4_rx_count", 32'(rx_count), 32'd0);
    master_write(TX_PKT, 8'h40, cyc);
    chk("t4_hold_txe", 32'(bus_if.fifo_txe_n), 32'd1);
    bus_if.fifo_wr_n = 1'b0;
    m_drive          = 1'b1;
    m_data           = 8'hEE;
    @(negedge clk);
    bus_if.fifo_wr_n = 1'b1;
    m_drive          = 1'b0;
    @(negedge clk);
    chk("t4_tx_count", 32'(tx_count), 32'(TX_PKT));
    chk("t4_err_over", 32'(err), 32'b110);
    sync_clear();
    chk("t4_err_clr", 32'(err), 32'd0);

    // 5: contention
    host_push(8'h5C);
    @(negedge clk);
    idle();
    @(negedge clk);
    bus_if.fifo_oe_n = 1'b0;
    bus_if.fifo_wr_n = 1'b0;
    #1;
    chk("t5_bus", 32'(fifo_data), 32'h5C);
    @(negedge clk);
    idle();
    chk("t5_err", 32'(err), 32'b001);
    chk("t5_tx_count", 32'(tx_count), 32'd0);
    sync_clear();

    // 6: asynchronous reset in the middle of a read burst
    master_write(5, 8'h80, cyc);
    for (int i = 0; i < 8; i++) host_push(8'h20 + 8'(i));
    @(negedge clk);
    idle();
    bus_if.fifo_oe_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus_if.fifo_rd_n = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("t6_mid_count", 32'(rx_count), 32'd5);
    reset_i = 1'b1;
    #1;
    chk("t6_async_rxf", 32'(bus_if.fifo_rxf_n), 32'd1);
    chk("t6_async_txe", 32'(bus_if.fifo_txe_n), 32'd1);
    tick(2);
    reset_i = 1'b0;
    idle();
    tick(2);
    chk("t6_rx_count", 32'(rx_count), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_empty", 32'(host_rd_empty), 32'd1);

    // Random mixed traffic in both directions
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      host_wr_en   = ($urandom_range(0, 2) != 0);
      host_wr_data = 8'($urandom);
      host_rd_en   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) begin
        bus_if.fifo_oe_n = 1'b0;
        bus_if.fifo_wr_n = 1'b1;
        m_drive          = 1'b0;
        bus_if.fifo_rd_n = (bus_if.fifo_rxf_n === 1'b0 && $urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      end else begin
        bus_if.fifo_oe_n = 1'b1;
        bus_if.fifo_rd_n = 1'b1;
        bus_if.fifo_wr_n = (bus_if.fifo_txe_n === 1'b0 && $urandom_range(0, 1) == 1) ? 1'b0 : 1'b1;
        m_drive          = 1'b1;
        m_data           = 8'($urandom);
      end
    end
    @(negedge clk);
    idle();
    tick(2);
    chk("rand_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
